// File: rtl/rr_arb_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_4
// Brief    : 4-requester round-robin arbiter (enable + index) with grant hold,
//            release-by-done/drop/timeout and a forced idle gap between grants.
//            Optional sticky timeout_flag output under RR_ARB_TIMEOUT_FLAG_EN.
// Revision : 1.0
// ============================================================================
module rr_arb_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
`ifdef RR_ARB_TIMEOUT_FLAG_EN
    output logic       timeout_flag,
`endif
    output logic       grant_vld,
    output logic [1:0] grant_idx
);

    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : CNT_W'(0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ptr;
    logic [1:0]       ptr_nxt;
    logic [1:0]       idx_nxt;
    logic [1:0]       winner;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             found;
    logic             timeout_hit;
    logic             release_now;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr + 2'(i)]) begin
                winner = ptr + 2'(i);
                found  = 1'b1;
            end
        end
    end

    assign timeout_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign release_now = done | ~req[grant_idx] | timeout_hit;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = grant_idx;
        cnt_nxt   = hold_cnt;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    idx_nxt   = winner;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt = IDLE;
                    ptr_nxt   = grant_idx + 2'd1;
                end else if (hold_cnt != {CNT_W{1'b1}}) begin
                    cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'b00;
            grant_idx <= 2'b00;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant_idx <= idx_nxt;
            hold_cnt  <= cnt_nxt;
        end
    end

    // The state flop itself is the enable, so no extra register is needed.
    assign grant_vld = (state == GRANT);

`ifdef RR_ARB_TIMEOUT_FLAG_EN
    logic flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag <= 1'b0;
        end else if (state == GRANT && timeout_hit && !done && req[grant_idx]) begin
            flag <= 1'b1;
        end
    end

    assign timeout_flag = flag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_4
// Brief    : Self-checking bench for rr_arb_4 with MAX_HOLD = 8, 4 and 0.
// Revision : 1.0
// ============================================================================
module tb_rr_arb_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [2:0] vld;
    logic [1:0] idx [3];
`ifdef RR_ARB_TIMEOUT_FLAG_EN
    logic [2:0] flg;
`endif

    int total = 0;
    int bad   = 0;

    rr_arb_4 #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
`ifdef RR_ARB_TIMEOUT_FLAG_EN
        .timeout_flag(flg[0]),
`endif
        .grant_vld(vld[0]), .grant_idx(idx[0])
    );

    rr_arb_4 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
`ifdef RR_ARB_TIMEOUT_FLAG_EN
        .timeout_flag(flg[1]),
`endif
        .grant_vld(vld[1]), .grant_idx(idx[1])
    );

    rr_arb_4 #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
`ifdef RR_ARB_TIMEOUT_FLAG_EN
        .timeout_flag(flg[2]),
`endif
        .grant_vld(vld[2]), .grant_idx(idx[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks how many cycles the current owner has held.
    int       mh [3] = '{8, 4, 0};
    bit       m_vld  [3];
    bit [1:0] m_idx  [3];
    bit [1:0] m_ptr  [3];
    int       m_held [3];
    bit       m_flag [3];
    bit       m_found;
    int       m_c;
    bit       m_to;

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                m_vld[d]  = 1'b0;
                m_idx[d]  = 2'd0;
                m_ptr[d]  = 2'd0;
                m_held[d] = 0;
                m_flag[d] = 1'b0;
            end else if (!m_vld[d]) begin
                if (req != 4'b0000) begin
                    m_found = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        m_c = (int'(m_ptr[d]) + k) % 4;
                        if (!m_found && req[m_c]) begin
                            m_idx[d] = 2'(m_c);
                            m_found  = 1'b1;
                        end
                    end
                    m_vld[d]  = 1'b1;
                    m_held[d] = 1;
                end
            end else begin
                m_to = (mh[d] != 0) && (m_held[d] >= mh[d]);
                if (done || !req[m_idx[d]] || m_to) begin
                    if (m_to && !done && req[m_idx[d]]) m_flag[d] = 1'b1;
                    m_vld[d] = 1'b0;
                    m_ptr[d] = 2'((int'(m_idx[d]) + 1) % 4);
                end else begin
                    m_held[d] = m_held[d] + 1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        req   = 4'b0000;
        done  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (vld !== 3'b000 || idx[0] !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: vld=%b idx=%0d expected vld=000 idx=0", vld, idx[0]);
        end
        rst_n = 1'b1;
        req   = 4'b0100;
        @(negedge clk);
        total++;
        if (vld[0] !== 1'b1 || idx[0] !== 2'd2) begin
            bad++;
            $display("FAIL reset_pre_grant: vld=%b idx=%0d expected vld=1 idx=2", vld[0], idx[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (vld !== 3'b000 || idx[0] !== 2'd0) begin
            bad++;
            $display("FAIL reset_async: vld=%b idx=%0d expected vld=000 idx=0", vld, idx[0]);
        end
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (vld !== 3'b000 || idx[0] !== 2'd0) begin
                bad++;
                $display("FAIL reset_idle_after: cyc=%0d vld=%b idx=%0d expected vld=000 idx=0", i, vld, idx[0]);
            end
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        total++;
        if (vld[0] !== 1'b1 || idx[0] !== 2'd2) begin
            bad++;
            $display("FAIL single_grant: vld=%b idx=%0d expected vld=1 idx=2", vld[0], idx[0]);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        total++;
        if (vld[0] !== 1'b0 || idx[0] !== 2'd2) begin
            bad++;
            $display("FAIL single_release: vld=%b idx=%0d expected vld=0 idx=2", vld[0], idx[0]);
        end
        req = 4'b1111;
        @(negedge clk);
        total++;
        if (vld[0] !== 1'b1 || idx[0] !== 2'd3) begin
            bad++;
            $display("FAIL single_next_ptr: vld=%b idx=%0d expected vld=1 idx=3", vld[0], idx[0]);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_rotation();
        bit [1:0] exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            total++;
            if (vld[0] !== 1'b1 || idx[0] !== exp_idx[g]) begin
                bad++;
                $display("FAIL rotation_grant: g=%0d vld=%b idx=%0d expected vld=1 idx=%0d", g, vld[0], idx[0], exp_idx[g]);
            end
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            total++;
            if (vld[0] !== 1'b0) begin
                bad++;
                $display("FAIL rotation_gap: g=%0d vld=%b expected 0", g, vld[0]);
            end
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (vld[1] !== 1'b1 || idx[1] !== 2'd0) begin
                bad++;
                $display("FAIL timeout_hold: cyc=%0d vld=%b idx=%0d expected vld=1 idx=0", i, vld[1], idx[1]);
            end
        end
        @(negedge clk);
        total++;
        if (vld[1] !== 1'b0) begin
            bad++;
            $display("FAIL timeout_gap: vld=%b expected 0", vld[1]);
        end
        @(negedge clk);
        total++;
        if (vld[1] !== 1'b1 || idx[1] !== 2'd0) begin
            bad++;
            $display("FAIL timeout_regrant: vld=%b idx=%0d expected vld=1 idx=0", vld[1], idx[1]);
        end
`ifdef RR_ARB_TIMEOUT_FLAG_EN
        total++;
        if (flg[1] !== 1'b1 || flg[2] !== 1'b0) begin
            bad++;
            $display("FAIL timeout_flag: flag4=%b flag0=%b expected flag4=1 flag0=0", flg[1], flg[2]);
        end
`endif
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        total++;
        if (vld[0] !== 1'b1 || idx[0] !== 2'd1) begin
            bad++;
            $display("FAIL drop_owner: vld=%b idx=%0d expected vld=1 idx=1", vld[0], idx[0]);
        end
        req = 4'b1000;
        @(negedge clk);
        total++;
        if (vld[0] !== 1'b0 || idx[0] !== 2'd1) begin
            bad++;
            $display("FAIL drop_release: vld=%b idx=%0d expected vld=0 idx=1", vld[0], idx[0]);
        end
        @(negedge clk);
        total++;
        if (vld[0] !== 1'b1 || idx[0] !== 2'd3) begin
            bad++;
            $display("FAIL drop_next: vld=%b idx=%0d expected vld=1 idx=3", vld[0], idx[0]);
        end
`ifdef RR_ARB_TIMEOUT_FLAG_EN
        total++;
        if (flg[0] !== 1'b0) begin
            bad++;
            $display("FAIL drop_flag: flag=%b expected 0", flg[0]);
        end
`endif
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_unlimited();
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            total++;
            if (vld[2] !== 1'b1 || idx[2] !== 2'd0) begin
                bad++;
                $display("FAIL unlimited_hold: cyc=%0d vld=%b idx=%0d expected vld=1 idx=0", i, vld[2], idx[2]);
            end
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                total++;
                if (vld[d] !== m_vld[d] || idx[d] !== m_idx[d]) begin
                    bad++;
                    $display("FAIL random_model: cyc=%0d dut=%0d vld=%b idx=%0d expected vld=%b idx=%0d",
                             i, d, vld[d], idx[d], m_vld[d], m_idx[d]);
                end
`ifdef RR_ARB_TIMEOUT_FLAG_EN
                total++;
                if (flg[d] !== m_flag[d]) begin
                    bad++;
                    $display("FAIL random_flag: cyc=%0d dut=%0d flag=%b expected %b", i, d, flg[d], m_flag[d]);
                end
`endif
            end
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            done = ($urandom_range(0, 5) == 0);
        end
        req  = 4'b0000;
        done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_rotation();
        test_timeout();
        test_req_drop();
        test_unlimited();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
